serie_divisao_seq: RTL and testbench
====================================

# serie_divisao_seq

Sequential evaluator of the alternating division series v = m/a − m/(a+2) + m/(a+4) − …, with m = 4·2^60 (4 scaled by 15 hex fractional digits). It does the divisions with one shared shift-subtract divider, so the board's SWI→LCD datapath needs no combinational 63-bit dividers. It takes a divisor byte from the switches with a start/busy/done handshake and holds the 61-bit fixed-point result (1 hex integer digit, 15 hex fractional digits) for lcd_b.

## Interface
- NTERMS, 8, number of series terms (even; 8 = four +/− pairs)
- QTD_FRAC, 15, hex fractional digits; scale t = 2^(4·QTD_FRAC)
- ASIZE, 8, divisor input width
- clk_2  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  ASIZE  base divisor, latched when start is accepted
- busy  output  1  high from acceptance until result is written
- done  output  1  one-cycle pulse; v valid from this cycle on
- div0  output  1  sticky per run; set if any term divided by zero
- v  output  1+4·QTD_FRAC (61)  result, held until next accepted start

## Operation
- Derived widths: MSIZE = 3+4·QTD_FRAC (63) dividend/quotient/accumulator; DSIZE = ASIZE+1 (9) term divisor (max 255+2·(NTERMS−1) = 269 fits).
- FSM states: IDLE, LOAD, DIV, ACC, DONE.
- IDLE: start=1 → latch a, clear acc and div0, k←0 → LOAD. start=0 → stay.
- LOAD: divisor d = a + 2k (DSIZE bits), dividend m, remainder 0, iteration counter ← MSIZE−1 → DIV.
- DIV: one restoring step per cycle, MSB first: r' = {r, next dividend bit}; if r' ≥ d then r = r' − d and quotient bit = 1, else r = r' and bit = 0. After MSIZE steps → ACC.
- d = 0: no special case; the quotient comes out all ones (2^63−1). div0 ← 1.
- ACC: acc ← acc + q if k even, acc − q if k odd. Arithmetic is MSIZE-bit modulo 2^MSIZE. k ← k+1. If k = NTERMS−1 → DONE, else → LOAD.
- DONE: v ← acc[60:0] (modulo 2^61, wrap intended), done=1 → IDLE.
- start while not IDLE is ignored (no queueing). a is not sampled again during a run.
- Reset (any state, including mid-DIV): state IDLE, busy 0, done 0, div0 0, v 0, acc 0, k 0. The run is abandoned.

## Timing
- Start accepted at edge E0 → busy high from the cycle after E0.
- Each term takes 1 LOAD + MSIZE DIV + 1 ACC = 65 cycles.
- done is high in the single cycle beginning at edge E0 + NTERMS·65 (520 for defaults). busy is low in that cycle. v updates on the same edge.
- Earliest next accept is the edge after the done cycle (done lasts exactly 1 cycle).
- Reset values: busy 0, done 0, div0 0, v 0.

## Structure
- Package divisao_pkg: QTD_FRAC, QTD_BITS_HEX = 4, MSIZE, sizeSaidaHex, state enum type (IDLE, LOAD, DIV, ACC, DONE).
- Sub-module divisor_restaurador (ports clk_2, reset, load, dividend[MSIZE], divisor[DSIZE], quotient, busy/last). It holds the remainder/quotient shift registers and the iteration counter.
- The top FSM owns k, acc, sign selection, div0 and the output registers.
- Top instantiation: a ← SWI, lcd_b ← zero-extended v.

## Test plan
- NTERMS=2, a=4, start pulse → done exactly 130 cycles after the accept edge. v = 0x0555555555555556 (0x1000000000000000 − 0x0AAAAAAAAAAAAAAA). div0 = 0.
- NTERMS=1, a=2 → quotient 2^61 wraps. v = 0, done at 65 cycles.
- divisor_restaurador alone: 2^62 / 3 → quotient 0x1555555555555555, remainder 1, after 63 steps.
- a=0, defaults → div0 = 1. v equals the bench golden model, which uses the all-ones first quotient and modulo-2^61 sum.
- start re-pulsed at cycles 10 and 300 of a run → ignored. Single done at 520, result equals a=latched value.
- reset asserted at cycle 100 of a run → next cycle busy=0, v=0, div0=0. A new start with a=4, NTERMS=2 completes normally (130 cycles, same v as the first scenario).

Source files
------------

// File: rtl/divisao_pkg.sv
// Shared constants and FSM state type for the alternating division series evaluator.
package divisao_pkg;

    // Hex fractional digits of the result and bits per hex digit.
    localparam int unsigned QTD_FRAC     = 15;
    localparam int unsigned QTD_BITS_HEX = 4;

    // Dividend/quotient/accumulator width: 4 * 2^(4*QTD_FRAC) needs 3 integer bits.
    localparam int unsigned MSIZE        = 3 + QTD_BITS_HEX * QTD_FRAC;

    // Hex digits shown on the LCD: one integer digit plus the fraction.
    localparam int unsigned sizeSaidaHex = 1 + QTD_FRAC;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/divisor_restaurador.sv
// Restoring shift-subtract divider: one quotient bit per cycle, MSB first.
// A load pulse captures dividend and divisor; 'last' marks the cycle of the final step,
// after which 'quotient' holds the result until the next load.
module divisor_restaurador
    import divisao_pkg::*;
#(
    parameter int unsigned MWIDTH = MSIZE,
    parameter int unsigned DWIDTH = 9
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              load,
    input  logic [MWIDTH-1:0] dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic [MWIDTH-1:0] quotient,
    output logic              last
);

    localparam int unsigned CW = $clog2(MWIDTH);

    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [DWIDTH-1:0] rem_q;
    logic [DWIDTH-1:0] dsr_q;
    logic [DWIDTH-1:0] rem_d;
    logic [MWIDTH-1:0] quo_q;
    logic [DWIDTH:0]   rem_ext;
    logic              ge;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    // A zero divisor always "fits", so the quotient comes out all ones.
    always_comb begin
        rem_ext = {rem_q, quo_q[MWIDTH-1]};
        ge      = rem_ext >= {1'b0, dsr_q};
        rem_d   = ge ? DWIDTH'(rem_ext - {1'b0, dsr_q}) : rem_ext[DWIDTH-1:0];
    end

    // Dividend bits shift out of quo_q as quotient bits shift in; counter runs MWIDTH-1 to 0.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
        end else if (load) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(MWIDTH - 1);
            rem_q  <= '0;
            dsr_q  <= divisor;
            quo_q  <= dividend;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[MWIDTH-2:0], ge};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign quotient = quo_q;
    assign last     = busy_q && (cnt_q == '0);

endmodule

// File: rtl/serie_divisao_seq.sv
// Sequential evaluator of v = m/a - m/(a+2) + m/(a+4) - ... with m = 4 * 2^(4*QTD_FRAC),
// sharing one restoring divider across all terms. Result is fixed point with one hex
// integer digit and QTD_FRAC hex fractional digits, held until the next accepted start.
module serie_divisao_seq #(
    parameter int unsigned NTERMS   = 8,
    parameter int unsigned QTD_FRAC = divisao_pkg::QTD_FRAC,
    parameter int unsigned ASIZE    = 8
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ASIZE-1:0]      a,
    output logic                  busy,
    output logic                  done,
    output logic                  div0,
    output logic [4*QTD_FRAC:0]   v
);

    import divisao_pkg::*;

    localparam int unsigned MW = 3 + QTD_BITS_HEX * QTD_FRAC;
    localparam int unsigned VW = 1 + QTD_BITS_HEX * QTD_FRAC;
    localparam int unsigned DW = ASIZE + 1;
    localparam int unsigned KW = $clog2(NTERMS) + 1;

    localparam logic [KW-1:0] K_LAST = KW'(NTERMS - 1);
    // m = 4 * 2^(4*QTD_FRAC) = 2^(MW-1)
    localparam logic [MW-1:0] M_DIVIDEND = {1'b1, {(MW - 1){1'b0}}};

    state_t           state_q, state_d;
    logic [ASIZE-1:0] a_q, a_d;
    logic [KW-1:0]    k_q, k_d;
    logic [MW-1:0]    acc_q, acc_d;
    logic             div0_q, div0_d;
    logic [VW-1:0]    v_q, v_d;

    logic [DW-1:0]    divisor;
    logic [MW-1:0]    quot;
    logic [MW-1:0]    term;
    logic             div_load;
    logic             div_last;

    assign divisor = DW'(a_q) + DW'({k_q, 1'b0});

    divisor_restaurador #(
        .MWIDTH (MW),
        .DWIDTH (DW)
    ) u_divisor (
        .clk_2    (clk_2),
        .reset    (reset),
        .load     (div_load),
        .dividend (M_DIVIDEND),
        .divisor  (divisor),
        .quotient (quot),
        .last     (div_last)
    );

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            div0_q  <= 1'b0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            div0_q  <= div0_d;
            v_q     <= v_d;
        end
    end

    // Next-state logic, term sign selection and handshake outputs.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        k_d      = k_q;
        acc_d    = acc_q;
        div0_d   = div0_q;
        v_d      = v_q;
        busy     = 1'b0;
        done     = 1'b0;
        div_load = 1'b0;
        // Even terms add, odd terms subtract; modulo 2^MW.
        term     = k_q[0] ? (acc_q - quot) : (acc_q + quot);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    acc_d   = '0;
                    div0_d  = 1'b0;
                    k_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                div_load = 1'b1;
                if (divisor == '0) begin
                    div0_d = 1'b1;
                end
                state_d = DIV;
            end
            DIV: begin
                busy = 1'b1;
                if (div_last) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                busy  = 1'b1;
                acc_d = term;
                k_d   = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // Write v on entry to DONE so it is valid in the done cycle itself.
                    v_d     = term[VW-1:0];
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign div0 = div0_q;
    assign v    = v_q;

endmodule

// File: tb/tb_serie_divisao_seq.sv
// Scoreboard bench: stimulus pushes expected results, per-instance monitors pop on done.
module tb_serie_divisao_seq;

    typedef struct {
        logic [60:0] v;
        logic        div0;
        logic [63:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic [63:0] cyc = 64'd0;
    int          checks = 0;
    int          errors = 0;

    exp_t q8[$];
    exp_t q2[$];
    exp_t q1[$];
    exp_t e8, e2, e1;

    // Three instances: default 8 terms, 2 terms and 1 term.
    logic        rst8, start8, busy8, done8, div0_8;
    logic [7:0]  a8;
    logic [60:0] v8;
    logic        rst2, start2, busy2, done2, div0_2;
    logic [7:0]  a2;
    logic [60:0] v2;
    logic        rst1, start1, busy1, done1, div0_1;
    logic [7:0]  a1;
    logic [60:0] v1;

    // Standalone divider.
    logic        drst, dload, dlast;
    logic [62:0] ddividend, dquot;
    logic [8:0]  ddivisor;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 64'd1;

    serie_divisao_seq dut8 (
        .clk_2 (clk), .reset (rst8), .start (start8), .a (a8),
        .busy (busy8), .done (done8), .div0 (div0_8), .v (v8)
    );

    serie_divisao_seq #(.NTERMS(2)) dut2 (
        .clk_2 (clk), .reset (rst2), .start (start2), .a (a2),
        .busy (busy2), .done (done2), .div0 (div0_2), .v (v2)
    );

    serie_divisao_seq #(.NTERMS(1)) dut1 (
        .clk_2 (clk), .reset (rst1), .start (start1), .a (a1),
        .busy (busy1), .done (done1), .div0 (div0_1), .v (v1)
    );

    divisor_restaurador #(.MWIDTH(63), .DWIDTH(9)) u_div (
        .clk_2 (clk), .reset (drst), .load (dload), .dividend (ddividend),
        .divisor (ddivisor), .quotient (dquot), .last (dlast)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Golden model: integer division, all-ones quotient for d=0, modulo-2^63 accumulation.
    function automatic logic [60:0] model(input int unsigned n, input int unsigned av);
        logic [62:0]     acc;
        logic [62:0]     q;
        longint unsigned d;
        acc = '0;
        for (int unsigned k = 0; k < n; k++) begin
            d = longint'(av + 2 * k);
            if (d == 0) q = '1;
            else q = 63'(64'h4000_0000_0000_0000 / d);
            acc = (k % 2 == 1) ? acc - q : acc + q;
        end
        return acc[60:0];
    endfunction

    // Issue one start pulse to the selected instance and push its expected result.
    task automatic go(input int n, input logic [7:0] av, input logic [60:0] ev, input logic ed);
        exp_t e;
        @(negedge clk);
        e.v    = ev;
        e.div0 = ed;
        e.cyc  = cyc + 64'd1 + 64'(n * 65);
        case (n)
            8: begin a8 = av; start8 = 1'b1; q8.push_back(e); end
            2: begin a2 = av; start2 = 1'b1; q2.push_back(e); end
            default: begin a1 = av; start1 = 1'b1; q1.push_back(e); end
        endcase
        @(negedge clk);
        start8 = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
    endtask

    // Wait, bounded, until every outstanding expectation has been consumed.
    task automatic drain(input string name);
        int n = 0;
        while ((q8.size() + q2.size() + q1.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d results outstanding", name,
                     q8.size() + q2.size() + q1.size());
            q8.delete();
            q2.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    // Monitor for the 8-term instance.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8 done: unexpected pulse at cycle %0d", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("dut8 v", 64'(v8), 64'(e8.v));
                chk("dut8 div0", 64'(div0_8), 64'(e8.div0));
                chk("dut8 done cycle", cyc, e8.cyc);
                chk("dut8 busy in done", 64'(busy8), 64'd0);
            end
        end
    end

    // Monitor for the 2-term instance.
    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2 done: unexpected pulse at cycle %0d", cyc);
            end else begin
                e2 = q2.pop_front();
                chk("dut2 v", 64'(v2), 64'(e2.v));
                chk("dut2 div0", 64'(div0_2), 64'(e2.div0));
                chk("dut2 done cycle", cyc, e2.cyc);
                chk("dut2 busy in done", 64'(busy2), 64'd0);
            end
        end
    end

    // Monitor for the 1-term instance.
    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 done: unexpected pulse at cycle %0d", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("dut1 v", 64'(v1), 64'(e1.v));
                chk("dut1 div0", 64'(div0_1), 64'(e1.div0));
                chk("dut1 done cycle", cyc, e1.cyc);
                chk("dut1 busy in done", 64'(busy1), 64'd0);
            end
        end
    end

    initial begin
        int n;
        rst8 = 1'b1; rst2 = 1'b1; rst1 = 1'b1; drst = 1'b1;
        start8 = 1'b0; start2 = 1'b0; start1 = 1'b0;
        a8 = '0; a2 = '0; a1 = '0;
        dload = 1'b0; ddividend = '0; ddivisor = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset div0", 64'(div0_8), 64'd0);
        chk("reset v", 64'(v8), 64'd0);
        rst8 = 1'b0; rst2 = 1'b0; rst1 = 1'b0; drst = 1'b0;

        // Divider alone: 2^62 / 3.
        @(negedge clk);
        ddividend = 63'h4000_0000_0000_0000;
        ddivisor  = 9'd3;
        dload     = 1'b1;
        @(negedge clk);
        dload = 1'b0;
        n = 1;
        while (!dlast && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("divider steps", 64'(n), 64'd63);
        @(negedge clk);
        chk("divider quotient", 64'(dquot), 64'h1555_5555_5555_5555);
        chk("divider remainder", 64'(u_div.rem_q), 64'd1);

        // Two terms, a=4: 2^60 - 2^61/3.
        go(2, 8'd4, 61'h0555_5555_5555_5556, 1'b0);
        // One term, a=2: quotient 2^61 wraps to 0 in the 61-bit result.
        go(1, 8'd2, 61'h0, 1'b0);
        drain("first runs");
        // One term, a=3.
        go(1, 8'd3, 61'h1555_5555_5555_5555, 1'b0);
        // Two terms, a=0: all-ones first quotient minus 2^61.
        go(2, 8'd0, 61'h1FFF_FFFF_FFFF_FFFF, 1'b1);
        drain("a0 two terms");

        // Default terms with divide by zero.
        go(8, 8'd0, model(8, 0), 1'b1);
        drain("a0 eight terms");
        // Largest divisor byte.
        go(8, 8'd255, model(8, 255), 1'b0);
        drain("a255");

        // Start re-pulsed with a different a during the run must be ignored.
        go(8, 8'd1, model(8, 1), 1'b0);
        repeat (9) @(negedge clk);
        a8 = 8'd99;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (289) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain("repulse");
        repeat (20) @(negedge clk);
        chk("repulse no second run", 64'(busy8), 64'd0);

        // Reset in the middle of a run.
        go(2, 8'd0, 61'h1FFF_FFFF_FFFF_FFFF, 1'b1);
        repeat (98) @(negedge clk);
        chk("pre-reset busy", 64'(busy2), 64'd1);
        chk("pre-reset div0", 64'(div0_2), 64'd1);
        rst2 = 1'b1;
        q2.delete();
        @(negedge clk);
        chk("mid-run reset busy", 64'(busy2), 64'd0);
        chk("mid-run reset v", 64'(v2), 64'd0);
        chk("mid-run reset div0", 64'(div0_2), 64'd0);
        chk("mid-run reset done", 64'(done2), 64'd0);
        rst2 = 1'b0;
        go(2, 8'd4, 61'h0555_5555_5555_5556, 1'b0);
        drain("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
